// File: rtl/requant_pkg.sv
//------------------------------------------------------------------------------
// requant_pkg
// Shared widths, shift limit and requester-id type for the requantiser.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package requant_pkg;

    localparam int DW        = 32;
    localparam int EW        = 6;
    localparam int MAX_SHIFT = 31;
    localparam int SW        = $clog2(MAX_SHIFT + 1);

    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/round_shift_pow2.sv
//------------------------------------------------------------------------------
// round_shift_pow2
// Combinational signed divide by 2^e, round to nearest, ties away from zero.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module round_shift_pow2
    import requant_pkg::*;
#(
    parameter int DW_P = requant_pkg::DW,
    parameter int SW_P = requant_pkg::SW
) (
    input  logic [DW_P-1:0] dividend,
    input  logic [SW_P-1:0] e,
    output logic [DW_P-1:0] quotient
);

    logic            w_neg;
    logic [DW_P:0]   w_mag;
    logic [DW_P:0]   w_half;
    logic [DW_P:0]   w_sum;
    logic [DW_P:0]   w_shr;
    logic [DW_P:0]   w_neg_shr;

    // Work on the magnitude (one extra bit so the most negative value fits),
    // which makes "ties away from zero" a plain round-half-up.
    assign w_neg     = dividend[DW_P-1];
    assign w_mag     = w_neg ? ({1'b0, ~dividend} + (DW_P+1)'(1)) : {1'b0, dividend};
    assign w_half    = (e == '0) ? '0 : ((DW_P+1)'(1) << (e - SW_P'(1)));
    assign w_sum     = w_mag + w_half;
    assign w_shr     = w_sum >> e;
    assign w_neg_shr = (~w_shr) + (DW_P+1)'(1);

    always_comb begin
        quotient = w_shr[DW_P-1:0];
        if (e == '0) begin
            quotient = dividend;
        end else if (w_neg) begin
            quotient = w_neg_shr[DW_P-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/requant_shift_arb.sv
//------------------------------------------------------------------------------
// requant_shift_arb
// Two-requester round-robin front end sharing one two-stage rounding shifter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module requant_shift_arb
    import requant_pkg::*;
#(
    parameter int DW = requant_pkg::DW,
    parameter int EW = requant_pkg::EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_dividend,
    input  logic [EW-1:0] req0_exponent,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_dividend,
    input  logic [EW-1:0] req1_exponent,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quotient,
    output logic          out_id,
    output logic          out_clamped
);

    localparam logic [EW-1:0] c_max_exp   = EW'(requant_pkg::MAX_SHIFT);
    localparam logic [requant_pkg::SW-1:0] c_max_shift = requant_pkg::SW'(requant_pkg::MAX_SHIFT);

    logic                        r_s1_valid;
    logic [DW-1:0]               r_s1_dividend;
    logic [requant_pkg::SW-1:0]  r_s1_e;
    req_id_t                     r_s1_id;
    logic                        r_s1_clamp;

    logic                        r_s2_valid;
    logic [DW-1:0]               r_s2_quotient;
    req_id_t                     r_s2_id;
    logic                        r_s2_clamp;

    req_id_t                     r_last_grant;

    logic                        w_s2_adv;
    logic                        w_s1_adv;
    req_id_t                     w_grant;
    logic                        w_accept;
    logic [DW-1:0]               w_sel_dividend;
    logic [EW-1:0]               w_sel_exp;
    logic                        w_sel_clamp;
    logic [requant_pkg::SW-1:0]  w_sel_e;
    logic [DW-1:0]               w_quotient;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Round robin: contention goes to the requester not served last.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = !r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = w_s1_adv && (req0_valid || req1_valid);
    assign req0_ready = rst_n && w_s1_adv && (w_grant == 1'b0);
    assign req1_ready = rst_n && w_s1_adv && (w_grant == 1'b1);

    assign w_sel_dividend = w_grant ? req1_dividend : req0_dividend;
    assign w_sel_exp      = w_grant ? req1_exponent : req0_exponent;
    assign w_sel_clamp    = w_sel_exp > c_max_exp;
    assign w_sel_e        = w_sel_clamp ? c_max_shift : w_sel_exp[requant_pkg::SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_dividend <= '0;
            r_s1_e        <= '0;
            r_s1_id       <= 1'b0;
            r_s1_clamp    <= 1'b0;
            r_last_grant  <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_dividend <= w_sel_dividend;
                r_s1_e        <= w_sel_e;
                r_s1_id       <= w_grant;
                r_s1_clamp    <= w_sel_clamp;
                r_last_grant  <= w_grant;
            end
        end
    end

    round_shift_pow2 #(
        .DW_P (DW),
        .SW_P (requant_pkg::SW)
    ) u_round (
        .dividend (r_s1_dividend),
        .e        (r_s1_e),
        .quotient (w_quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_quotient <= '0;
            r_s2_id       <= 1'b0;
            r_s2_clamp    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_quotient <= w_quotient;
                r_s2_id       <= r_s1_id;
                r_s2_clamp    <= r_s1_clamp;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_quotient = r_s2_quotient;
    assign out_id       = r_s2_id;
    assign out_clamped  = r_s2_clamp;

endmodule

`default_nettype wire

// File: tb/tb_requant_shift_arb.sv
//------------------------------------------------------------------------------
// tb_requant_shift_arb
// Vector table, directed corner sequences and random traffic against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_requant_shift_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_dividend, req1_dividend;
    logic [5:0]  req0_exponent, req1_exponent;
    logic        out_valid, out_ready;
    logic [31:0] out_quotient;
    logic        out_id, out_clamped;

    int checks = 0;
    int errors = 0;

    requant_shift_arb #(.DW(32), .EW(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_dividend (req0_dividend),
        .req0_exponent (req0_exponent),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_dividend (req1_dividend),
        .req1_exponent (req1_exponent),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_id        (out_id),
        .out_clamped   (out_clamped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic        id;
        logic        cl;
        int          stamp;
    } item_t;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  x;
        logic [31:0] q;
        logic        cl;
    } vec_t;

    item_t pipe[$];
    logic  obs_ids[$];
    logic  m_last = 1'b1;
    int    cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round to nearest, ties away from zero, from plain integer division.
    function automatic logic [31:0] ref_round(input logic [31:0] d, input logic [5:0] x);
        longint sd, mag, p, qm;
        int     e;
        e  = (x > 6'd31) ? 31 : int'(x);
        sd = longint'($signed(d));
        if (e == 0) return d;
        mag = (sd < 0) ? -sd : sd;
        p   = longint'(1) << e;
        qm  = (mag + p / 2) / p;
        return (sd < 0) ? 32'(-qm) : 32'(qm);
    endfunction

    function automatic logic m_grant();
        if (req0_valid && req1_valid) return !m_last;
        if (req1_valid) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_room();
        return (pipe.size() < 2) || out_ready;
    endfunction

    function automatic bit m_out_valid();
        return (pipe.size() > 0) && (pipe[0].stamp + 1 < cyc);
    endfunction

    task automatic check_dut();
        bit g;
        g = m_grant();
        chk("req0_ready", req0_ready, m_room() && (g == 1'b0));
        chk("req1_ready", req1_ready, m_room() && (g == 1'b1));
        chk("out_valid", out_valid, m_out_valid());
        if (m_out_valid()) begin
            chk("out_quotient", out_quotient, pipe[0].q);
            chk("out_id", out_id, pipe[0].id);
            chk("out_clamped", out_clamped, pipe[0].cl);
            if (out_ready) obs_ids.push_back(out_id);
        end
    endtask

    task automatic model_edge();
        bit    g, acc;
        item_t it;
        g   = m_grant();
        acc = m_room() && (req0_valid || req1_valid);
        if (m_out_valid() && out_ready) void'(pipe.pop_front());
        if (acc) begin
            it.id    = g;
            it.q     = g ? ref_round(req1_dividend, req1_exponent) : ref_round(req0_dividend, req0_exponent);
            it.cl    = g ? (req1_exponent > 6'd31) : (req0_exponent > 6'd31);
            it.stamp = cyc;
            pipe.push_back(it);
            m_last = g;
        end
        cyc++;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_dut();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit v0, input bit v1, input bit ordy);
        req0_valid    = v0;
        req1_valid    = v1;
        req0_dividend = $urandom();
        req1_dividend = $urandom();
        req0_exponent = 6'($urandom_range(0, 63));
        req1_exponent = 6'($urandom_range(0, 63));
        out_ready     = ordy;
    endtask

    vec_t        vecs[8];
    logic [31:0] held_q;
    logic        held_id, held_cl;

    initial begin
        vecs[0] = '{32'd7,        6'd1,  32'd4,        1'b0};
        vecs[1] = '{32'hFFFFFFF9, 6'd1,  32'hFFFFFFFC, 1'b0};
        vecs[2] = '{32'hFFFFFFFA, 6'd2,  32'hFFFFFFFE, 1'b0};
        vecs[3] = '{32'd5,        6'd2,  32'd1,        1'b0};
        vecs[4] = '{32'h7FFFFFFF, 6'd1,  32'h40000000, 1'b0};
        vecs[5] = '{32'h80000000, 6'd31, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{32'h80000000, 6'd0,  32'h80000000, 1'b0};
        vecs[7] = '{32'd100,      6'd40, 32'd0,        1'b1};

        // Reset state, with both requesters asking.
        rst_n = 1'b0;
        drive(1, 1, 1);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_quotient", out_quotient, 32'd0);
        chk("rst_out_id", out_id, 1'b0);
        chk("rst_out_clamped", out_clamped, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1);

        // Vector table through req0, checking the two-edge latency.
        foreach (vecs[i]) begin
            req0_valid    = 1'b1;
            req0_dividend = vecs[i].d;
            req0_exponent = vecs[i].x;
            req1_valid    = 1'b0;
            out_ready     = 1'b1;
            step();
            req0_valid = 1'b0;
            chk("vec_lat1_valid", out_valid, 1'b0);
            step();
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_quotient", out_quotient, vecs[i].q);
            chk("vec_id", out_id, 1'b0);
            chk("vec_clamped", out_clamped, vecs[i].cl);
        end
        drive(0, 0, 1);
        repeat (3) step();

        // Fill both stages under stall, then reset mid-cycle.
        repeat (3) begin
            drive(1, 1, 0);
            step();
        end
        chk("full_out_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_req0_ready", req0_ready, 1'b0);
        chk("midrst_req1_ready", req1_ready, 1'b0);
        chk("midrst_out_quotient", out_quotient, 32'd0);
        pipe.delete();
        m_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Arbitration: contention alternates starting with req0.
        obs_ids.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1);
            #1;
            chk("arb_req0_ready", req0_ready, (i % 2) == 0);
            chk("arb_req1_ready", req1_ready, (i % 2) == 1);
            step();
        end
        drive(0, 0, 1);
        repeat (4) step();
        chk("arb_count", obs_ids.size(), 4);
        for (int i = 0; i < 4 && i < obs_ids.size(); i++) begin
            chk("arb_out_id", obs_ids[i], (i % 2) == 1);
        end

        // Backpressure: held outputs under a 5-cycle stall while streaming.
        repeat (3) begin
            drive(1, 1, 1);
            step();
        end
        held_q  = out_quotient;
        held_id = out_id;
        held_cl = out_clamped;
        chk("bp_valid_before", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0);
            step();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_quotient", out_quotient, held_q);
            chk("bp_hold_id", out_id, held_id);
            chk("bp_hold_clamped", out_clamped, held_cl);
        end
        repeat (4) begin
            drive(1, 1, 1);
            step();
        end
        drive(0, 0, 1);
        repeat (4) step();
        chk("bp_drained", pipe.size(), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) req0_exponent = 6'd0;
            if ($urandom_range(0, 7) == 0) req1_exponent = 6'd31;
            step();
        end
        drive(0, 0, 1);
        repeat (4) step();
        chk("rand_drained", pipe.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
